// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: lamp/state types and default timing shared by the intersection controller.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        GREEN  = 2'b01,
        YELLOW = 2'b10,
        OFF    = 2'b11
    } traffic_light_t;

    typedef enum logic [1:0] {
        ST_ALL_RED,
        ST_GREEN,
        ST_YELLOW
    } tl_state_t;

    localparam int DEF_N_WAYS         = 4;
    localparam int DEF_GREEN_CYCLES   = 5;
    localparam int DEF_YELLOW_CYCLES  = 2;
    localparam int DEF_ALL_RED_CYCLES = 1;

    function automatic int tl_max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/tl_rr_arbiter.sv
// tl_rr_arbiter: combinational circular search for the first request after the last-served index.
module tl_rr_arbiter #(
    parameter  int N  = 4,
    localparam int AW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [AW-1:0] i_last,
    output logic [AW-1:0] o_grant,
    output logic          o_valid
);

    logic [AW-1:0] w_idx;

    // Scan farthest to nearest so the closest request after i_last wins; i_last itself is checked last.
    always_comb begin
        o_grant = i_last;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = AW'((int'(i_last) + k) % N);
            if (i_req[w_idx]) begin
                o_grant = w_idx;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_intersection.sv
// traffic_intersection: N-way signal controller with fixed or request-driven rotation and emergency preemption.
module traffic_intersection
    import traffic_light_pkg::*;
#(
    parameter  int N_WAYS         = DEF_N_WAYS,
    parameter  int GREEN_CYCLES   = DEF_GREEN_CYCLES,
    parameter  int YELLOW_CYCLES  = DEF_YELLOW_CYCLES,
    parameter  int ALL_RED_CYCLES = DEF_ALL_RED_CYCLES,
    localparam int AW             = $clog2(N_WAYS)
) (
    input  logic              clk,
    input  logic              asyn_reset,
    input  logic              actuated,
    input  logic              emerg,
    input  logic [N_WAYS-1:0] req,
    output traffic_light_t    lights [N_WAYS],
    output logic [AW-1:0]     active_way,
    output logic              green_start,
    output logic              all_red
);

    localparam int CW = $clog2(tl_max3(GREEN_CYCLES, YELLOW_CYCLES, ALL_RED_CYCLES) + 1);

    tl_state_t         r_state, w_state;
    logic [CW-1:0]     r_cnt, w_cnt;
    logic [AW-1:0]     r_way, w_way;
    logic [N_WAYS-1:0] r_pend, w_pend;
    logic              r_gs;
    logic [AW-1:0]     w_grant, w_next;
    logic              w_grant_vld, w_exp, w_other, w_enter;
    logic [N_WAYS-1:0] w_own, w_new_hot;

    tl_rr_arbiter #(.N(N_WAYS)) u_arb (
        .i_req   (r_pend),
        .i_last  (r_way),
        .o_grant (w_grant),
        .o_valid (w_grant_vld)
    );

    assign w_exp     = r_cnt <= CW'(1);
    assign w_next    = (r_way == AW'(N_WAYS - 1)) ? '0 : r_way + AW'(1);
    assign w_own     = N_WAYS'(1) << r_way;
    assign w_other   = |(r_pend & ~w_own);
    assign w_new_hot = N_WAYS'(1) << w_way;
    assign w_enter   = (w_state == ST_GREEN) && (r_state != ST_GREEN);

    always_comb begin
        w_state = r_state;
        w_way   = r_way;
        w_cnt   = w_exp ? r_cnt : r_cnt - CW'(1);
        case (r_state)
            ST_ALL_RED: begin
                if (emerg) begin
                    w_cnt = CW'(ALL_RED_CYCLES);
                end else if (w_exp && (!actuated || w_grant_vld)) begin
                    w_state = ST_GREEN;
                    w_cnt   = CW'(GREEN_CYCLES);
                    w_way   = actuated ? w_grant : w_next;
                end
            end
            ST_GREEN: begin
                if (emerg || (w_exp && (!actuated || w_other))) begin
                    w_state = ST_YELLOW;
                    w_cnt   = CW'(YELLOW_CYCLES);
                end
            end
            ST_YELLOW: begin
                if (w_exp) begin
                    w_state = ST_ALL_RED;
                    w_cnt   = CW'(ALL_RED_CYCLES);
                end
            end
            default: begin
                w_state = ST_ALL_RED;
                w_cnt   = CW'(ALL_RED_CYCLES);
            end
        endcase
        // The way currently lit cannot request itself; entering green consumes that way's request.
        w_pend = (r_pend | (req & ((r_state == ST_ALL_RED) ? '1 : ~w_own))) & (w_enter ? ~w_new_hot : '1);
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            r_state <= ST_ALL_RED;
            r_cnt   <= CW'(ALL_RED_CYCLES);
            r_way   <= AW'(N_WAYS - 1);
            r_pend  <= '0;
            r_gs    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_way   <= w_way;
            r_pend  <= w_pend;
            r_gs    <= w_enter;
        end
    end

    always_comb begin
        for (int i = 0; i < N_WAYS; i++) begin
            lights[i] = (AW'(i) != r_way)      ? RED    :
                        (r_state == ST_GREEN)  ? GREEN  :
                        (r_state == ST_YELLOW) ? YELLOW : RED;
        end
    end

    assign active_way  = r_way;
    assign green_start = r_gs;
    assign all_red     = r_state == ST_ALL_RED;

endmodule

// File: tb/tb_traffic_intersection.sv
// tb_traffic_intersection: randomized scoreboard bench against a remaining-time behavioural model.
module tb_traffic_intersection;
    import traffic_light_pkg::*;

    localparam int N  = 4;
    localparam int G  = 5;
    localparam int Y  = 2;
    localparam int AR = 1;
    localparam int PH_RED = 0, PH_GRN = 1, PH_YEL = 2;

    logic           clk = 1'b0, asyn_reset = 1'b0, actuated = 1'b0, emerg = 1'b0;
    logic [N-1:0]   req = '0;
    traffic_light_t lights [N];
    logic [1:0]     active_way;
    logic           green_start, all_red;

    logic           rst2 = 1'b1;
    traffic_light_t lights2 [2];
    logic           active_way2, green_start2, all_red2;

    traffic_intersection #(.N_WAYS(N), .GREEN_CYCLES(G), .YELLOW_CYCLES(Y), .ALL_RED_CYCLES(AR)) u_dut (
        .clk(clk), .asyn_reset(asyn_reset), .actuated(actuated), .emerg(emerg), .req(req),
        .lights(lights), .active_way(active_way), .green_start(green_start), .all_red(all_red)
    );

    traffic_intersection #(.N_WAYS(2), .GREEN_CYCLES(G), .YELLOW_CYCLES(Y), .ALL_RED_CYCLES(AR)) u_dut2 (
        .clk(clk), .asyn_reset(rst2), .actuated(1'b0), .emerg(1'b0), .req(2'b00),
        .lights(lights2), .active_way(active_way2), .green_start(green_start2), .all_red(all_red2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2*N-1:0] lt;
        logic [1:0]     way;
        logic           gs;
        logic           ar;
    } exp_t;

    exp_t     q[$];
    int       checks = 0, errors = 0;
    int       m_ph, m_left, m_way;
    bit [N-1:0] m_pend;
    bit       m_gs;
    int       g2 = 0;
    bit       e2 = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        e.lt = '0;
        for (int i = 0; i < N; i++)
            if (i == m_way) e.lt[2*i +: 2] = (m_ph == PH_GRN) ? 2'b01 : (m_ph == PH_YEL) ? 2'b10 : 2'b00;
        e.way = 2'(m_way);
        e.gs  = m_gs;
        e.ar  = (m_ph == PH_RED);
        return e;
    endfunction

    task automatic model_reset();
        m_ph = PH_RED; m_left = AR; m_way = N - 1; m_pend = '0; m_gs = 1'b0;
    endtask

    // Each call advances the model by one clock edge given the inputs seen at that edge.
    task automatic model_step(input bit a, input bit em, input bit [N-1:0] rq);
        bit [N-1:0] np;
        int nw;
        bit other;
        np = m_pend;
        nw = -1;
        other = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rq[i] && !(i == m_way && m_ph != PH_RED)) np[i] = 1'b1;
            if (i != m_way && m_pend[i]) other = 1'b1;
        end
        m_gs = 1'b0;
        if (m_ph == PH_RED) begin
            if (em) m_left = AR;
            else if (m_left > 1) m_left--;
            else if (!a) nw = (m_way + 1) % N;
            else for (int k = 1; k <= N; k++) if (nw < 0 && m_pend[(m_way + k) % N]) nw = (m_way + k) % N;
            if (nw >= 0) begin
                m_ph = PH_GRN; m_left = G; m_way = nw; np[nw] = 1'b0; m_gs = 1'b1;
            end
        end else if (m_ph == PH_GRN) begin
            if (em || (m_left <= 1 && (!a || other))) begin
                m_ph = PH_YEL; m_left = Y;
            end else if (m_left > 1) m_left--;
        end else begin
            if (m_left > 1) m_left--;
            else begin
                m_ph = PH_RED; m_left = AR;
            end
        end
        m_pend = np;
    endtask

    task automatic step(input bit r, input bit a, input bit e, input logic [N-1:0] rq);
        @(negedge clk);
        if (r) begin
            model_reset();
            q.push_back(expect_now());
            #1 asyn_reset = 1'b1;
            #2 asyn_reset = 1'b0;
        end
        actuated = a; emerg = e; req = rq;
        model_step(a, e, rq);
        q.push_back(expect_now());
    endtask

    initial begin : monitor
        exp_t e;
        logic [2*N-1:0] lt;
        forever begin
            @(posedge clk or posedge asyn_reset);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int i = 0; i < N; i++) lt[2*i +: 2] = lights[i];
                chk("lights", 32'(lt), 32'(e.lt));
                chk("active_way", 32'(active_way), 32'(e.way));
                chk("green_start", 32'(green_start), 32'(e.gs));
                chk("all_red", 32'(all_red), 32'(e.ar));
            end
        end
    end

    initial begin : monitor2
        forever begin
            @(posedge clk);
            #1;
            if (!rst2 && green_start2) begin
                chk("n2_way", 32'(active_way2), 32'(e2));
                e2 = ~e2;
                g2++;
            end
        end
    end

    initial begin : stim
        bit did_yrst;
        int eleft;
        bit a;
        logic [N-1:0] rq;
        did_yrst = 1'b0;
        #12 rst2 = 1'b0;
        // Fixed rotation, with one asynchronous reset dropped into way N-1's yellow.
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 80; i++) begin
            step(m_ph == PH_YEL && m_way == N - 1 && !did_yrst, 1'b0, 1'b0, '0);
            if (m_ph == PH_RED && m_way == N - 1) did_yrst = 1'b1;
        end
        // Actuated hold on way 2, then a request on way 0 skips way 1.
        step(1'b1, 1'b1, 1'b0, 4'b0100);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 4'b0001);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, '0);
        // Emergency raised in the second green cycle of way 1.
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 100 && !(m_ph == PH_GRN && m_way == 1 && m_left == G - 1); i++) step(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, '0);
        // Own request held through its own green.
        step(1'b1, 1'b1, 1'b0, 4'b0010);
        for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b0, 4'b0010);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, '0);
        // Random traffic, mode changes, emergency bursts and occasional resets.
        eleft = 0;
        a = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (i % 40 == 0) a = 1'($urandom_range(0, 1));
            if (eleft > 0) eleft--;
            else if ($urandom_range(0, 99) < 3) eleft = $urandom_range(1, 12);
            for (int b = 0; b < N; b++) rq[b] = ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 299) == 0, a, eleft > 0, rq);
        end
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("n2_greens_seen", 32'(g2 >= 4), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_intersection.md
TRAFFIC_INTERSECTION -- requirements
Module: traffic_intersection

Interface
REQ-001 Parameter N_WAYS, 4, number of approaches; legal range 2..8.
REQ-002 Parameter GREEN_CYCLES, 5, minimum green duration in clk cycles; legal range 1 or more.
REQ-003 Parameter YELLOW_CYCLES, 2, yellow duration in clk cycles; legal range 1 or more.
REQ-004 Parameter ALL_RED_CYCLES, 1, all-red clearance duration in clk cycles; legal range 1 or more.
REQ-005 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 Port asyn_reset  input  1  reset, asynchronous, active-high.
REQ-007 Port actuated  input  1  mode select: 0 = fixed rotation, 1 = request-driven.
REQ-008 Port emerg  input  1  emergency preemption, level-sensitive.
REQ-009 Port req  input  N_WAYS  per-way vehicle request, level or pulse.
REQ-010 Port lights  output  N_WAYS x traffic_light_t  per-way lamp state.
REQ-011 Port active_way  output  $clog2(N_WAYS)  index of the way owning the current or most recent green.
REQ-012 Port green_start  output  1  one-cycle pulse in the first cycle of every green.
REQ-013 Port all_red  output  1  high while every way shows RED.

Function
REQ-014 The FSM SHALL have the states ST_ALL_RED, ST_GREEN and ST_YELLOW, with a down-counter of width $clog2(max(GREEN_CYCLES, YELLOW_CYCLES, ALL_RED_CYCLES)+1).
REQ-015 Lights SHALL be Moore-decoded from the state and active_way, with zero cycles of latency:
  - ST_GREEN: lights[active_way] = GREEN.
  - ST_YELLOW: lights[active_way] = YELLOW.
  - All other ways, and every way in ST_ALL_RED: RED.
REQ-016 Each timed state SHALL last exactly its parameter's number of cycles; on every state entry the counter loads the value for the new state.
REQ-017 ST_ALL_RED expiry, actuated=0: go to ST_GREEN with active_way = (active_way+1) mod N_WAYS.
REQ-018 ST_ALL_RED expiry, actuated=1: go to ST_GREEN for the first pending way found circularly after active_way; if none is pending, stay in ST_ALL_RED and re-check each cycle.
REQ-019 A pending register (N_WAYS bits) SHALL update every cycle:
  - Set bit i when req[i]=1, except while way i is in ST_GREEN or ST_YELLOW.
  - Clear bit i on entry to green for way i.
REQ-020 ST_GREEN expiry, actuated=0: go to ST_YELLOW.
REQ-021 ST_GREEN expiry, actuated=1:
  - If some other way is pending: go to ST_YELLOW.
  - Otherwise: extend green, re-checking each cycle; leave for ST_YELLOW the cycle after another way becomes pending.
REQ-022 ST_YELLOW expiry SHALL go to ST_ALL_RED.
REQ-023 emerg=1 in ST_GREEN SHALL force ST_YELLOW on the next edge, regardless of the counter.
REQ-024 In ST_YELLOW, emerg has no effect; yellow always completes.
REQ-025 ST_ALL_RED SHALL NOT exit while emerg=1; after emerg falls, the full ALL_RED_CYCLES clearance runs again.
REQ-026 Rotation and arbitration SHALL wrap from index N_WAYS-1 to index 0.
REQ-027 green_start SHALL be 1 exactly in the first ST_GREEN cycle; all_red SHALL equal (state == ST_ALL_RED).
REQ-028 A change of actuated SHALL take effect at the next expiry decision only.

Reset
REQ-029 Asserting asyn_reset SHALL immediately, with no clock edge needed, set:
  - state = ST_ALL_RED and counter = ALL_RED_CYCLES;
  - active_way = N_WAYS-1 and pending = 0;
  - every light RED, green_start = 0, all_red = 1.
REQ-030 After reset deasserts in fixed mode, the first green SHALL be way 0, ALL_RED_CYCLES cycles later.
REQ-031 Reset during any state, including mid-yellow, SHALL abandon that phase with no completion.

Structure
REQ-032 traffic_light_pkg SHALL hold:
  - traffic_light_t, a 2-bit enum: RED=2'b00, GREEN=2'b01, YELLOW=2'b10, OFF=2'b11 (OFF unused here).
  - tl_state_t.
  - The default timing constants.
REQ-033 The next-way search SHALL be a combinational sub-module tl_rr_arbiter:
  - Inputs: request vector, last index.
  - Outputs: grant index, valid.

Verification (N_WAYS=4, GREEN=5, YELLOW=2, ALL_RED=1 unless noted)
REQ-034 Fixed-rotation sequence:
  - Stimulus: reset, actuated=0, no req.
  - Response: greens 0,1,2,3,0; each green 5 cycles, yellow 2 cycles, all-red 1 cycle; period 32 cycles; green_start once per green.
REQ-035 Actuated green hold:
  - Stimulus: actuated=1; 1-cycle req[2] pulse while all-red.
  - Response: way 2 green after the all-red expires; green held past 5 cycles with no other request.
  - Stimulus: then req[0] pulse.
  - Response: yellow on the next edge, then 1 cycle all-red, then way 0 green (way 1 skipped).
REQ-036 Emergency preemption:
  - Stimulus: emerg=1 in green cycle 2 of way 1, held 10 cycles.
  - Response: yellow next cycle for 2 cycles; all-red held while emerg=1; way 2 green 1 cycle after emerg falls.
REQ-037 Async reset mid-yellow:
  - Stimulus: asyn_reset pulsed between clock edges during way 3 yellow.
  - Response: all lights RED immediately, active_way=3; way 0 green 1 cycle after release.
REQ-038 Own-request ignore: req[active_way] held high through its green and yellow, actuated=1, no other req -> pending[active_way] stays 0 and the green is held.
REQ-039 Minimum-size wrap: N_WAYS=2, actuated=0 -> greens alternate 0,1,0,1; active_way never exceeds 1.
